// File: rtl/fir_axis_requant.sv
// fir_axis_requant: round/shift/saturate signed FIR results onto a narrower AXI-Stream through a 2-entry skid FIFO
module fir_axis_requant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int ROUND = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    s_axis_tdata,
  input  logic [IN_W/8-1:0]  s_axis_tkeep,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [OUT_W-1:0]   m_axis_tdata,
  output logic [OUT_W/8-1:0] m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic               clear_stats,
  output logic [15:0]        sat_count,
  output logic [31:0]        beat_count
);
  localparam int KW = OUT_W / 8;
  localparam int EW = OUT_W + KW + 2;
  localparam logic [IN_W:0] RND = (ROUND != 0 && SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [IN_W:0] MAXV = $signed({{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W:0] MINV = $signed({{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});
  logic signed [IN_W:0] r, y;
  logic                 sat_hi, sat_lo, keep_nz, accept, wr, emit;
  logic [OUT_W-1:0]     q_data;
  logic [EW-1:0]        new_entry, head;
  logic [1:0][EW-1:0]   mem_q, mem_d;
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tready_q, tready_d;
  logic [15:0]          sat_q, sat_d;
  logic [31:0]          beat_q, beat_d;
  // Requantize the incoming beat; an entry is {data, keep, last, sat}, empty-keep tlast beats become a zero marker
  always_comb begin
    r         = $signed({s_axis_tdata[IN_W-1], s_axis_tdata} + RND);
    y         = r >>> SHIFT;
    sat_hi    = y > MAXV;
    sat_lo    = y < MINV;
    q_data    = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} : sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : y[OUT_W-1:0];
    keep_nz   = |s_axis_tkeep;
    new_entry = keep_nz ? {q_data, {KW{1'b1}}, s_axis_tlast, sat_hi | sat_lo} : {{(OUT_W+KW){1'b0}}, s_axis_tlast, 1'b0};
  end
  // FIFO bookkeeping; tready is registered from the next occupancy so downstream ready never reaches it combinationally
  always_comb begin
    head             = mem_q[rd_ptr_q];
    accept           = s_axis_tvalid & tready_q;
    wr               = accept & (keep_nz | s_axis_tlast);
    emit             = (count_q != 2'd0) & m_axis_tready;
    count_d          = count_q + {1'b0, wr} - {1'b0, emit};
    mem_d            = mem_q;
    mem_d[wr_ptr_q]  = wr ? new_entry : mem_q[wr_ptr_q];
    wr_ptr_d         = wr_ptr_q ^ wr;
    rd_ptr_d         = rd_ptr_q ^ emit;
    tready_d         = count_d < 2'd2;
    beat_d           = clear_stats ? '0 : beat_q + 32'(emit);
    sat_d            = clear_stats ? '0 : sat_q + 16'(emit & head[0] & (sat_q != 16'hFFFF));
  end
  // State update; reset empties the FIFO and discards anything buffered
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      tready_q <= 1'b0;
      sat_q    <= '0;
      beat_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tready_q <= tready_d;
      sat_q    <= sat_d;
      beat_q   <= beat_d;
    end
  end
  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = count_q != 2'd0;
  assign m_axis_tdata  = head[EW-1 -: OUT_W];
  assign m_axis_tkeep  = head[KW+1:2];
  assign m_axis_tlast  = head[1];
  assign sat_count     = sat_q;
  assign beat_count    = beat_q;
endmodule

// File: tb/tb_fir_axis_requant.sv
// tb_fir_axis_requant: directed checks of requantization, skid FIFO, tkeep handling, reset and statistics
module tb_fir_axis_requant;
  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0, clear_stats = 1'b0;
  logic        s_tready, m_tlast, m_tvalid;
  logic [15:0] m_tdata, sat_count;
  logic [1:0]  m_tkeep;
  logic [31:0] beat_count;
  int          errors = 0, checks = 0;
  fir_axis_requant dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .clear_stats(clear_stats), .sat_count(sat_count), .beat_count(beat_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
  endtask
  initial begin
    logic [31:0] vin [4];
    logic [15:0] vout [4];
    vin  = '{32'h00010000, 32'h00004000, 32'hFFFFC000, 32'h00007FFF};
    vout = '{16'h0002, 16'h0001, 16'h0000, 16'h0001};
    step();
    step();
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_sat", sat_count, 0);
    chk("rst_beat", beat_count, 0);
    reset = 1'b1;
    step();
    chk("rel_s_tready", s_tready, 1);
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(vin[i], 4'hF, 1'b0);
      step();
      chk("basic_valid", m_tvalid, 1);
      chk("basic_data", m_tdata, vout[i]);
    end
    s_tvalid = 1'b0;
    step();
    chk("basic_drain", m_tvalid, 0);
    chk("basic_sat", sat_count, 0);
    chk("basic_beat", beat_count, 4);
    drive(32'h7FFFFFFF, 4'hF, 1'b0);
    step();
    chk("sat_pos", m_tdata, 16'h7FFF);
    drive(32'h80000000, 4'hF, 1'b0);
    step();
    chk("sat_neg", m_tdata, 16'h8000);
    s_tvalid = 1'b0;
    step();
    chk("sat_count2", sat_count, 2);
    chk("sat_beat6", beat_count, 6);
    m_tready = 1'b0;
    drive(32'd1 << 15, 4'hF, 1'b0);
    step();
    chk("bp1_data", m_tdata, 1);
    chk("bp1_rdy", s_tready, 1);
    s_tdata = 32'd2 << 15;
    step();
    chk("bp2_rdy", s_tready, 0);
    chk("bp2_data", m_tdata, 1);
    s_tdata = 32'd3 << 15;
    step();
    chk("bp3_rdy", s_tready, 0);
    chk("bp3_data", m_tdata, 1);
    m_tready = 1'b1;
    step();
    chk("bp4_data", m_tdata, 2);
    chk("bp4_rdy", s_tready, 1);
    for (int k = 3; k <= 5; k++) begin
      s_tdata = k << 15;
      step();
      chk("bp_stream_data", m_tdata, k);
      chk("bp_stream_rdy", s_tready, 1);
    end
    s_tvalid = 1'b0;
    step();
    chk("bp_drain", m_tvalid, 0);
    chk("bp_beat", beat_count, 11);
    drive(32'h12345678, 4'h0, 1'b0);
    step();
    chk("keep0_drop", m_tvalid, 0);
    drive(32'h00008000, 4'hF, 1'b0);
    step();
    chk("keepF_data", m_tdata, 1);
    chk("keepF_keep", m_tkeep, 2'b11);
    chk("keepF_last", m_tlast, 0);
    drive(32'h7FFFFFFF, 4'h0, 1'b1);
    step();
    chk("keep0l_valid", m_tvalid, 1);
    chk("keep0l_data", m_tdata, 0);
    chk("keep0l_keep", m_tkeep, 0);
    chk("keep0l_last", m_tlast, 1);
    s_tvalid = 1'b0;
    step();
    chk("keep_drain", m_tvalid, 0);
    chk("keep_beat", beat_count, 13);
    chk("keep_sat", sat_count, 2);
    m_tready = 1'b0;
    drive(32'h00010000, 4'hF, 1'b0);
    step();
    s_tdata = 32'h00020000;
    step();
    chk("pre_rst_rdy", s_tready, 0);
    s_tvalid = 1'b0;
    reset = 1'b0;
    step();
    chk("mid_rst_valid", m_tvalid, 0);
    chk("mid_rst_rdy", s_tready, 0);
    chk("mid_rst_beat", beat_count, 0);
    chk("mid_rst_sat", sat_count, 0);
    chk("mid_rst_data", m_tdata, 0);
    reset = 1'b1;
    step();
    chk("post_rst_rdy", s_tready, 1);
    chk("post_rst_valid", m_tvalid, 0);
    m_tready = 1'b1;
    step();
    chk("post_rst_nodata", m_tvalid, 0);
    chk("post_rst_beat", beat_count, 0);
    m_tready = 1'b0;
    drive(32'h7FFFFFFF, 4'hF, 1'b0);
    step();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("clr_sat", sat_count, 0);
    chk("clr_beat", beat_count, 0);
    chk("clr_fifo", m_tvalid, 0);
    drive(32'h7FFFFFFF, 4'hF, 1'b0);
    for (int i = 0; i < 65535; i++) step();
    chk("sticky_pre", sat_count, 16'hFFFE);
    for (int i = 0; i < 5; i++) step();
    s_tvalid = 1'b0;
    step();
    chk("sticky_sat", sat_count, 16'hFFFF);
    chk("sticky_beat", beat_count, 65540);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
